result_bcd_display: RTL and testbench

- Downstream stage of the 6-bit calculator top: consumes the 2*WIDTH-bit ALU result and converts it to sign plus four BCD digits.
- Conversion is sequential double-dabble, one bit per clock.
- Drives four active-low seven-segment digits and a sign indicator.
- Uses a start/busy/done handshake so the top latches a new result only after each operation completes.

---
 rtl/result_bcd_display_if.sv | 34 +++
 rtl/result_bcd_display.sv | 158 +++++++++++++++
 tb/tb_result_bcd_display.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/result_bcd_display_if.sv
`default_nettype none
// ============================================================================
// Module   : result_bcd_display_if
// Brief    : Handshake, value and display bundle for the BCD result display.
// Revision : 1.0 - initial release
// ============================================================================
interface result_bcd_display_if #(
   parameter int WIDTH  = 6,
   parameter int DIGITS = 4
);
   logic                  start;
   logic [2*WIDTH-1:0]    value;
   logic                  signed_mode;
   logic                  busy;
   logic                  done;
   logic                  neg;
   logic [4*DIGITS-1:0]   bcd;
   logic [6:0]            seg_d0;
   logic [6:0]            seg_d1;
   logic [6:0]            seg_d2;
   logic [6:0]            seg_d3;
   logic [6:0]            seg_sign;

   modport master (
      output start, value, signed_mode,
      input  busy, done, neg, bcd, seg_d0, seg_d1, seg_d2, seg_d3, seg_sign
   );

   modport slave (
      input  start, value, signed_mode,
      output busy, done, neg, bcd, seg_d0, seg_d1, seg_d2, seg_d3, seg_sign
   );
endinterface
`default_nettype wire

// File: rtl/result_bcd_display.sv
`default_nettype none
// ============================================================================
// Module   : result_bcd_display
// Brief    : Sign + BCD conversion (double-dabble, one bit per clock) of the
//            ALU result, driving active-low seven-segment digits.
// Revision : 1.0 - initial release
// ============================================================================
module result_bcd_display #(
   parameter int WIDTH  = 6,
   parameter int DIGITS = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   result_bcd_display_if.slave  bus
);

   localparam int c_RW = 2 * WIDTH;
   localparam int c_BW = 4 * DIGITS;
   localparam int c_CW = $clog2(c_RW + 1);

   localparam logic [1:0] c_IDLE    = 2'd0;
   localparam logic [1:0] c_CONVERT = 2'd1;
   localparam logic [1:0] c_DONE    = 2'd2;

   localparam logic [6:0] c_BLANK = 7'b1111111;

   logic [1:0]       r_state;
   logic [1:0]       w_next_state;

   logic [c_RW-1:0]  r_shift;
   logic [c_BW-1:0]  r_acc;
   logic [c_CW-1:0]  r_cnt;
   logic             r_neg_pend;
   logic [c_BW-1:0]  r_bcd;
   logic             r_neg;

   logic             w_neg_in;
   logic [c_RW-1:0]  w_mag;
   logic [c_BW-1:0]  w_adj;
   logic             w_last;
   logic [DIGITS-1:0] w_lead;
   logic [6:0]       w_seg [DIGITS];

   // Modulo-2^c_RW negation still yields the full magnitude of the most
   // negative input (e.g. -2048 -> 12'h800), so no extra bit is needed.
   assign w_neg_in = bus.signed_mode & bus.value[c_RW-1];
   assign w_mag    = w_neg_in ? (c_RW'(0) - bus.value) : bus.value;
   assign w_last   = (r_cnt == c_CW'(c_RW));

   always_comb begin
      w_adj = r_acc;
      for (int i = 0; i < DIGITS; i++) begin
         if (r_acc[4*i +: 4] >= 4'd5)
            w_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
      end
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (rst)
         r_state <= c_IDLE;
      else
         r_state <= w_next_state;
   end

   // ---------------- FSM: next-state logic ----------------
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_IDLE:    if (bus.start) w_next_state = c_CONVERT;
         c_CONVERT: if (w_last)    w_next_state = c_DONE;
         c_DONE:                   w_next_state = c_IDLE;
         default:                  w_next_state = c_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      bus.busy = (r_state != c_IDLE);
      bus.done = (r_state == c_DONE);
   end

   // Datapath; display registers change only on the edge entering DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_shift    <= '0;
         r_acc      <= '0;
         r_cnt      <= '0;
         r_neg_pend <= 1'b0;
         r_bcd      <= '0;
         r_neg      <= 1'b0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (bus.start) begin
                  r_shift    <= w_mag;
                  r_acc      <= '0;
                  r_cnt      <= '0;
                  r_neg_pend <= w_neg_in;
               end
            end
            c_CONVERT: begin
               if (!w_last) begin
                  {r_acc, r_shift} <= {w_adj, r_shift} << 1;
                  r_cnt            <= r_cnt + 1'b1;
               end else begin
                  r_bcd <= r_acc;
                  r_neg <= r_neg_pend;
               end
            end
            default: ;
         endcase
      end
   end

   function automatic logic [6:0] seg_code(input logic [3:0] d);
      case (d)
         4'd0:    seg_code = 7'b1000000;
         4'd1:    seg_code = 7'b1111001;
         4'd2:    seg_code = 7'b0100100;
         4'd3:    seg_code = 7'b0110000;
         4'd4:    seg_code = 7'b0011001;
         4'd5:    seg_code = 7'b0010010;
         4'd6:    seg_code = 7'b0000010;
         4'd7:    seg_code = 7'b1111000;
         4'd8:    seg_code = 7'b0000000;
         4'd9:    seg_code = 7'b0010000;
         default: seg_code = c_BLANK;
      endcase
   endfunction

   // Leading-zero blanking: walk down from the top digit; digit 0 always shows.
   always_comb begin
      logic w_zero;
      w_zero = 1'b1;
      w_lead = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         w_zero    = w_zero && (r_bcd[4*i +: 4] == 4'd0);
         w_lead[i] = w_zero && (i != 0);
      end
   end

   generate
      for (genvar i = 0; i < DIGITS; i++) begin : g_seg
         assign w_seg[i] = w_lead[i] ? c_BLANK : seg_code(r_bcd[4*i +: 4]);
      end
   endgenerate

   assign bus.bcd      = r_bcd;
   assign bus.neg      = r_neg;
   assign bus.seg_d0   = w_seg[0];
   assign bus.seg_d1   = w_seg[1];
   assign bus.seg_d2   = w_seg[2];
   assign bus.seg_d3   = w_seg[3];
   assign bus.seg_sign = r_neg ? 7'b0111111 : c_BLANK;

endmodule
`default_nettype wire

// File: tb/tb_result_bcd_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_result_bcd_display
// Brief    : Self-checking bench for result_bcd_display against a decimal model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_result_bcd_display;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   logic [15:0] exp_bcd;
   logic        exp_neg;
   logic [6:0]  exp_seg [4];
   logic [6:0]  exp_sign;
   logic [15:0] last_bcd;

   logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

   result_bcd_display_if #(.WIDTH(6), .DIGITS(4)) bus ();

   result_bcd_display #(.WIDTH(6), .DIGITS(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Decimal model: magnitude, digits by division, blanking by magnitude range.
   task automatic model(input logic [11:0] v, input logic sm);
      int mag;
      int p;
      int d;
      exp_neg = sm && v[11];
      mag     = exp_neg ? (4096 - int'(v)) : int'(v);
      p       = 1;
      for (int i = 0; i < 4; i++) begin
         d = (mag / p) % 10;
         exp_bcd[4*i +: 4] = 4'(d);
         exp_seg[i] = (i > 0 && mag < p) ? 7'b1111111 : seg_tab[d];
         p = p * 10;
      end
      exp_sign = exp_neg ? 7'b0111111 : 7'b1111111;
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, "_bcd"},  bus.bcd,      exp_bcd);
      chk({tag, "_neg"},  bus.neg,      exp_neg);
      chk({tag, "_d0"},   bus.seg_d0,   exp_seg[0]);
      chk({tag, "_d1"},   bus.seg_d1,   exp_seg[1]);
      chk({tag, "_d2"},   bus.seg_d2,   exp_seg[2]);
      chk({tag, "_d3"},   bus.seg_d3,   exp_seg[3]);
      chk({tag, "_sign"}, bus.seg_sign, exp_sign);
   endtask

   task automatic do_conv(input logic [11:0] v, input logic sm, input string tag);
      int          n;
      logic [15:0] prev;
      prev = last_bcd;
      model(v, sm);
      @(negedge clk);
      bus.start       = 1'b1;
      bus.value       = v;
      bus.signed_mode = sm;
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk({tag, "_busy_start"}, bus.busy, 1);
      n = 0;
      while (bus.done !== 1'b1 && n < 40) begin
         if (n == 6) chk({tag, "_hold"}, bus.bcd, prev);
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_latency"}, n, 13);
      chk({tag, "_busy_done"}, bus.busy, 1);
      check_outputs(tag);
      last_bcd = exp_bcd;
      @(posedge clk); #1;
      chk({tag, "_busy_after"}, bus.busy, 0);
      chk({tag, "_done_after"}, bus.done, 0);
   endtask

   initial begin
      int pulses;
      int lat;
      checks          = 0;
      failures        = 0;
      last_bcd        = 16'h0000;
      rst             = 1'b1;
      bus.start       = 1'b0;
      bus.value       = '0;
      bus.signed_mode = 1'b0;

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      model(12'd0, 1'b0);
      chk("reset_busy", bus.busy, 0);
      chk("reset_done", bus.done, 0);
      check_outputs("reset");

      do_conv(12'h000, 1'b1, "zero");
      do_conv(12'h800, 1'b1, "neg2048");
      do_conv(12'h800, 1'b0, "u2048");
      do_conv(12'hFFF, 1'b0, "u4095");
      do_conv(12'd123, 1'b1, "s123");
      do_conv(12'hFFB, 1'b1, "neg5");

      // A second start while converting must be ignored.
      @(negedge clk);
      bus.start = 1'b1; bus.value = 12'd77; bus.signed_mode = 1'b0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (2) @(posedge clk);
      #1 bus.start = 1'b1; bus.value = 12'd999;
      @(posedge clk); #1;
      bus.start = 1'b0;
      pulses = 0;
      lat    = 0;
      for (int e = 4; e <= 30; e++) begin
         @(posedge clk); #1;
         if (bus.done === 1'b1) begin
            pulses++;
            lat = e;
         end
         if (e == 14) chk("overlap_busy_after", bus.busy, 0);
      end
      model(12'd77, 1'b0);
      chk("overlap_pulses", pulses, 1);
      chk("overlap_latency", lat, 13);
      check_outputs("overlap");
      last_bcd = exp_bcd;

      // Reset in the middle of a conversion abandons it.
      @(negedge clk);
      bus.start = 1'b1; bus.value = 12'd500; bus.signed_mode = 1'b0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model(12'd0, 1'b0);
      chk("midrst_busy", bus.busy, 0);
      chk("midrst_done", bus.done, 0);
      check_outputs("midrst");
      pulses = 0;
      for (int e = 0; e < 20; e++) begin
         @(posedge clk); #1;
         if (bus.done === 1'b1) pulses++;
      end
      chk("midrst_no_done", pulses, 0);
      last_bcd = 16'h0000;
      do_conv(12'd42, 1'b0, "after_rst");

      for (int i = 0; i < 20; i++) begin
         logic [11:0] rv;
         logic        rs;
         rv = 12'($urandom_range(0, 4095));
         rs = 1'($urandom_range(0, 1));
         do_conv(rv, rs, $sformatf("rand%0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
